// File: rtl/stream_mux_arbiter_if.sv
// Shared handshake bundle between the stream mux arbiter and its surroundings.
//   master modport: arbiter side (observes requests and stream handshake, drives select/grant).
//   slave modport : mux/endpoint side (drives requests and stream handshake, observes select).
//   enable     - permits new grants
//   req        - per-endpoint request, bit0=master1 .. bit4=slave3
//   tvalid/tready/tlast - shared stream handshake as seen at the mux
//   sel        - mux select code, 0 = none, i+1 = endpoint i
//   grant      - one-hot grant matching sel
//   busy       - a grant is held
//   timeout    - one-cycle pulse on watchdog release
//   beat_count - beats accepted in the current or most recent packet
interface stream_mux_arbiter_if #(
  parameter int unsigned NUM_REQ = 5,
  parameter int unsigned BEAT_W  = 16
);
  logic               enable;
  logic [NUM_REQ-1:0] req;
  logic               tvalid;
  logic               tready;
  logic               tlast;
  logic [2:0]         sel;
  logic [NUM_REQ-1:0] grant;
  logic               busy;
  logic               timeout;
  logic [BEAT_W-1:0]  beat_count;

  modport master (
    input  enable, req, tvalid, tready, tlast,
    output sel, grant, busy, timeout, beat_count
  );

  modport slave (
    output enable, req, tvalid, tready, tlast,
    input  sel, grant, busy, timeout, beat_count
  );
endinterface

// File: rtl/stream_mux_arbiter.sv
// Packet-level round-robin arbiter for the 5-way stream endpoint mux.
// Grants one requester at a time, holds the grant until the tlast beat is accepted,
// and frees a stalled grant with a watchdog.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - handshake bundle (master modport): enable/req/tvalid/tready/tlast in,
//           sel/grant/busy/timeout/beat_count out (all registered)
module stream_mux_arbiter #(
  parameter int unsigned NUM_REQ = 5,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8,
  parameter int unsigned BEAT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  stream_mux_arbiter_if.master bus
);

  localparam logic [TO_W-1:0] WdLast = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e             state_q;
  logic [2:0]         ptr_q;
  logic [2:0]         sel_q;
  logic [NUM_REQ-1:0] grant_q;
  logic               busy_q;
  logic               timeout_q;
  logic [BEAT_W-1:0]  beat_q;
  logic [TO_W-1:0]    wd_q;
  logic               started_q;

  logic               beat;
  logic [BEAT_W-1:0]  beat_inc;
  logic               pick_valid;
  logic [2:0]         pick_idx;
  logic [2:0]         cand;

  assign beat     = bus.tvalid & bus.tready;
  assign beat_inc = (beat_q == '1) ? beat_q : beat_q + 1'b1;

  // Round-robin search starting just after the last winner, wrapping modulo NUM_REQ.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = 3'((32'(ptr_q) + k) % NUM_REQ);
      if (!pick_valid && bus.req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= 3'd4;
      sel_q     <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      beat_q    <= '0;
      wd_q      <= '0;
      started_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.enable && pick_valid) begin
            state_q   <= StActive;
            ptr_q     <= pick_idx;
            sel_q     <= pick_idx + 3'd1;
            grant_q   <= NUM_REQ'(1) << pick_idx;
            busy_q    <= 1'b1;
            wd_q      <= '0;
            beat_q    <= '0;
            started_q <= 1'b0;
          end
        end
        StActive: begin
          if (beat && bus.tlast) begin
            // A last beat beats a simultaneous watchdog expiry.
            beat_q  <= beat_inc;
            state_q <= StIdle;
            sel_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end else if ((TIMEOUT != 0) && !beat && (wd_q == WdLast)) begin
            state_q   <= StIdle;
            sel_q     <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else if (!bus.req[ptr_q] && !started_q) begin
            // Owner withdrew before sending data; once started, req is ignored.
            state_q <= StIdle;
            sel_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end else if (beat) begin
            beat_q    <= beat_inc;
            started_q <= 1'b1;
            wd_q      <= '0;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.sel        = sel_q;
  assign bus.grant      = grant_q;
  assign bus.busy       = busy_q;
  assign bus.timeout    = timeout_q;
  assign bus.beat_count = beat_q;

endmodule

// File: tb/tb_stream_mux_arbiter.sv
module tb_stream_mux_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  stream_mux_arbiter_if #(.NUM_REQ(5), .BEAT_W(16)) bus ();

  stream_mux_arbiter #(
    .NUM_REQ(5),
    .TIMEOUT(8),
    .TO_W   (8),
    .BEAT_W (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic        en;
    logic [4:0]  req;
    logic        vld;
    logic        rdy;
    logic        last;
    logic [2:0]  sel;
    logic [4:0]  grant;
    logic        busy;
    logic        to;
    logic [15:0] beats;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic en, logic [4:0] req, logic vld, logic rdy, logic last,
                              logic [2:0] sel, logic [4:0] grant, logic busy, logic to,
                              logic [15:0] beats);
    vec_t v;
    v.en = en; v.req = req; v.vld = vld; v.rdy = rdy; v.last = last;
    v.sel = sel; v.grant = grant; v.busy = busy; v.to = to; v.beats = beats;
    vecs.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic en, logic [4:0] req, logic vld, logic rdy, logic last);
    bus.enable = en;
    bus.req    = req;
    bus.tvalid = vld;
    bus.tready = rdy;
    bus.tlast  = last;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    drive(1'b1, 5'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic run_vecs(int lo, int hi, string tag);
    for (int i = lo; i < hi; i++) begin
      drive(vecs[i].en, vecs[i].req, vecs[i].vld, vecs[i].rdy, vecs[i].last);
      tick();
      checks++;
      if ({bus.sel, bus.grant, bus.busy, bus.timeout, bus.beat_count} !==
          {vecs[i].sel, vecs[i].grant, vecs[i].busy, vecs[i].to, vecs[i].beats}) begin
        errors++;
        $display("FAIL %s[%0d]: got sel=%0d grant=%b busy=%b to=%b beats=%0d expected sel=%0d grant=%b busy=%b to=%b beats=%0d",
                 tag, i, bus.sel, bus.grant, bus.busy, bus.timeout, bus.beat_count,
                 vecs[i].sel, vecs[i].grant, vecs[i].busy, vecs[i].to, vecs[i].beats);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL sim_time_limit: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    int n1;
    drive(1'b1, 5'b0, 1'b0, 1'b0, 1'b0);

    // Test 1: 3-beat packet from master1 after reset.
    add(1, 5'b00001, 0, 0, 0, 3'd1, 5'b00001, 1, 0, 16'd0);
    add(1, 5'b00001, 1, 1, 0, 3'd1, 5'b00001, 1, 0, 16'd1);
    add(1, 5'b00001, 1, 1, 0, 3'd1, 5'b00001, 1, 0, 16'd2);
    add(1, 5'b00001, 1, 1, 1, 3'd0, 5'b00000, 0, 0, 16'd3);
    add(1, 5'b00000, 0, 0, 0, 3'd0, 5'b00000, 0, 0, 16'd3);
    n1 = vecs.size();
    // Test 2: all requesting, 1-beat packets, rotation 1..5,1.
    for (int k = 0; k < 6; k++) begin
      logic [2:0] s;
      logic [4:0] g;
      s = 3'((k % 5) + 1);
      g = 5'b00001 << (k % 5);
      add(1, 5'b11111, 0, 0, 0, s, g, 1, 0, 16'd0);
      add(1, 5'b11111, 1, 1, 1, 3'd0, 5'b00000, 0, 0, 16'd1);
    end
    add(1, 5'b00000, 0, 0, 0, 3'd0, 5'b00000, 0, 0, 16'd1);

    #2;
    chk("reset_sel", 32'(bus.sel), 32'd0);
    chk("reset_grant_busy_to", {27'd0, bus.grant}, 32'd0);
    chk("reset_flags", {30'd0, bus.busy, bus.timeout}, 32'd0);
    chk("reset_beats", 32'(bus.beat_count), 32'd0);

    do_reset();
    run_vecs(0, n1, "pkt3");
    do_reset();
    run_vecs(n1, vecs.size(), "rr");

    // Watchdog: slave2 granted, no beats.
    do_reset();
    drive(1'b1, 5'b01000, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) begin
      tick();
      chk($sformatf("to_hold_sel_%0d", c), 32'(bus.sel), 32'd4);
      chk($sformatf("to_hold_pulse_%0d", c), 32'(bus.timeout), 32'd0);
    end
    drive(1'b1, 5'b11001, 1'b0, 1'b0, 1'b0);
    tick();
    chk("to_release_sel", 32'(bus.sel), 32'd0);
    chk("to_pulse", 32'(bus.timeout), 32'd1);
    chk("to_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("to_next_sel", 32'(bus.sel), 32'd5);
    chk("to_pulse_gone", 32'(bus.timeout), 32'd0);
    // Last beat in the expiry cycle: beat wins, no pulse.
    for (int c = 0; c < 7; c++) tick();
    drive(1'b1, 5'b11001, 1'b1, 1'b1, 1'b1);
    tick();
    chk("tie_sel", 32'(bus.sel), 32'd0);
    chk("tie_pulse", 32'(bus.timeout), 32'd0);
    chk("tie_beats", 32'(bus.beat_count), 32'd1);

    // Request withdrawal before and after data.
    do_reset();
    drive(1'b1, 5'b00010, 1'b0, 1'b0, 1'b0);
    tick();
    chk("drop_grant", 32'(bus.sel), 32'd2);
    drive(1'b1, 5'b00000, 1'b0, 1'b0, 1'b0);
    tick();
    chk("drop_early_sel", 32'(bus.sel), 32'd0);
    chk("drop_early_to", 32'(bus.timeout), 32'd0);
    drive(1'b1, 5'b00010, 1'b0, 1'b0, 1'b0);
    tick();
    chk("drop_regrant", 32'(bus.sel), 32'd2);
    drive(1'b1, 5'b00010, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    drive(1'b1, 5'b00000, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("drop_late_hold_%0d", c), 32'(bus.sel), 32'd2);
    end
    drive(1'b1, 5'b00000, 1'b1, 1'b1, 1'b1);
    tick();
    chk("drop_late_rel", 32'(bus.sel), 32'd0);
    chk("drop_late_beats", 32'(bus.beat_count), 32'd3);

    // Enable deasserted mid-packet.
    do_reset();
    drive(1'b1, 5'b00001, 1'b0, 1'b0, 1'b0);
    tick();
    chk("en_grant", 32'(bus.sel), 32'd1);
    drive(1'b1, 5'b00001, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, 5'b00011, 1'b1, 1'b1, 1'b0);
    tick();
    chk("en_off_hold", 32'(bus.sel), 32'd1);
    drive(1'b0, 5'b00011, 1'b1, 1'b1, 1'b1);
    tick();
    chk("en_off_rel", 32'(bus.sel), 32'd0);
    chk("en_off_beats", 32'(bus.beat_count), 32'd3);
    drive(1'b0, 5'b00011, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("en_off_blocked_%0d", c), 32'(bus.sel), 32'd0);
      chk($sformatf("en_off_beats_hold_%0d", c), 32'(bus.beat_count), 32'd3);
    end
    drive(1'b1, 5'b00011, 1'b0, 1'b0, 1'b0);
    tick();
    chk("en_on_rr", 32'(bus.sel), 32'd2);
    chk("en_on_grant", {27'd0, bus.grant}, 32'b00010);

    // Asynchronous reset in the middle of a packet.
    do_reset();
    drive(1'b1, 5'b00100, 1'b0, 1'b0, 1'b0);
    tick();
    chk("rst_mid_grant", 32'(bus.sel), 32'd3);
    drive(1'b1, 5'b00100, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) tick();
    chk("rst_mid_beats", 32'(bus.beat_count), 32'd4);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_sel", 32'(bus.sel), 32'd0);
    chk("rst_async_grant", {27'd0, bus.grant}, 32'd0);
    chk("rst_async_busy", 32'(bus.busy), 32'd0);
    chk("rst_async_beats", 32'(bus.beat_count), 32'd0);
    drive(1'b1, 5'b10001, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_ptr_sel", 32'(bus.sel), 32'd1);
    chk("rst_ptr_grant", {27'd0, bus.grant}, 32'b00001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
